mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle MIPS datapath: one shared memory, one ALU, instruction register.
//  Decodes op/funct from the IR and sequences fetch, decode, execute, memory and writeback.
//  Drives every mux select and write enable; sits beside the datapath inside the processor core.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, j. Memory-wait handshake via memready.
// PARAMETERS
//  USE_MEMREADY  1  1: FETCH/MEMRD/MEMWR wait for memready; 0: memready ignored, treated as 1
//  STATE_W       4  width of the state register and of the dbg_state port
// PORTS
//  clk          in   1        clock, all state changes on posedge
//  reset        in   1        asynchronous, active-high; forces state FETCH
//  op           in   6        IR[31:26]
//  funct        in   6        IR[5:0]
//  zero         in   1        ALU zero flag
//  memready     in   1        memory access complete this cycle
//  iord         out  1        0: memory addr = PC; 1: memory addr = ALUOut
//  memwrite     out  1        memory write strobe
//  irwrite      out  1        load instruction register
//  regdst       out  1        0: rt; 1: rd as write register
//  memtoreg     out  1        0: ALUOut; 1: data reg as writeback data
//  regwrite     out  1        register file write enable
//  alusrca      out  1        0: PC; 1: regA
//  alusrcb      out  2        00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc        out  2        00 ALU result, 01 ALUOut, 10 jump target
//  alucontrol   out  3        010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcen         out  1        PC write enable
//  dbg_state    out  STATE_W  current state encoding
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7
//          BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11 BNEEX=12. Undriven outputs in a state are 0.
//  FETCH : iord=0 alusrca=0 alusrcb=01 aluop=00 pcsrc=00; irwrite=pcwrite=memready.
//          memready=1 -> DECODE, else stay (PC never double-increments).
//  DECODE: alusrca=0 alusrcb=11 aluop=00. op: 100011/101011->MEMADR, 000000->RTYPEEX,
//          000100->BEQEX, 000101->BNEEX, 001000->ADDIEX, 000010->JEX, any other->FETCH (NOP).
//  MEMADR: alusrca=1 alusrcb=10 aluop=00. lw->MEMRD, sw->MEMWR.
//  MEMRD : iord=1; memready -> MEMWB else stay.   MEMWB: regdst=0 memtoreg=1 regwrite=1 -> FETCH.
//  MEMWR : iord=1 memwrite=1 (held while waiting); memready -> FETCH else stay.
//  RTYPEEX: alusrca=1 alusrcb=00 aluop=10 -> RTYPEWB. RTYPEWB: regdst=1 regwrite=1 -> FETCH.
//  BEQEX/BNEEX: alusrca=1 alusrcb=00 aluop=01 pcsrc=01; branch / branchne -> FETCH.
//  ADDIEX: alusrca=1 alusrcb=10 aluop=00 -> ADDIWB. ADDIWB: regdst=0 regwrite=1 -> FETCH.
//  JEX   : pcsrc=10 pcwrite=1 -> FETCH.
//  pcen = pcwrite | (branch & zero) | (branchne & ~zero); combinational, same cycle as zero.
//  alucontrol: aluop 00->010, 01->110, 10 by funct: 100000->010 100010->110 100100->000
//          100101->001 101010->111, other funct->010. aluop 11 unused, maps to 010.
//  Outputs are Moore decode of state except irwrite/pcwrite (memready) and pcen (zero).
//  Cycles with memready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal op 2.
//  Reset: async assert -> state FETCH immediately. While reset=1, memwrite, irwrite, regwrite, pcen
//          forced 0; other outputs show FETCH values. Reset mid-instruction abandons it; no partial write.
//  Unreachable state encodings (13-15) -> FETCH next cycle, all enables 0.
// STRUCTURE
//  Package mips_ctrl_pkg: state enum, opcode constants (OP_LW OP_SW OP_RTYPE OP_BEQ OP_BNE OP_ADDI OP_J),
//          funct constants, alucontrol constants.
//  Sub-module mips_alu_decoder (combinational aluop+funct -> alucontrol); FSM, output decode, pcen here.
// TESTING
//  reset 1 for 2 cycles then 0, op=100011, memready=1 -> states 0,1,2,3,4,0; regwrite=1 memtoreg=1 in 4.
//  sw (op=101011), memready=0 for 3 cycles in MEMWR -> memwrite=1 and iord=1 held 4 cycles, then FETCH.
//  FETCH with memready low 2 cycles -> irwrite=pcen=0 in those cycles; 1 pulse on 3rd cycle.
//  beq zero=1 -> pcen=1 pcsrc=01 in BEQEX; bne zero=1 -> pcen=0; bne zero=0 -> pcen=1.
//  R-type funct=101010 -> alucontrol=111 in RTYPEEX, regdst=1 regwrite=1 in RTYPEWB; op=111111 -> FETCH after DECODE.
//  Assert reset in MEMWR with memwrite=1 -> memwrite 0 same cycle, dbg_state=0 without clock edge.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU control values and the control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUC_W    = 3;
  localparam int unsigned ALUOP_W   = 2;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned STATE_ENC = 4;

  typedef enum logic [STATE_ENC-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

  // Moore control word produced per state; irwrite/pcwrite are qualified by memready.
  typedef struct packed {
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [SEL_W-1:0] alusrcb;
    logic [SEL_W-1:0] pcsrc;
    aluop_t           aluop;
    logic             pcwrite;
    logic             branch;
    logic             branchne;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, selects and enables out.
interface mips_multicycle_ctrl_if
  import mips_ctrl_pkg::*;
  #(parameter int unsigned STATE_W = 4)
  ();

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               memready;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [SEL_W-1:0]   alusrcb;
  logic [SEL_W-1:0]   pcsrc;
  logic [ALUC_W-1:0]  alucontrol;
  logic               pcen;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, dbg_state
  );

  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, dbg_state
  );

endinterface

// File: rtl/mips_alu_decoder.sv
// Maps aluop and R-type funct to the 3-bit ALU control code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t             aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default:     alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath select and enable.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
  #(
    parameter bit          USE_MEMREADY = 1'b1,
    parameter int unsigned STATE_W      = 4
  )
  (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
  );

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   mem_done;

  assign mem_done = USE_MEMREADY ? bus.memready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
          OP_BNE:       state_nxt = S_BNEEX;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JEX;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_nxt = S_MEMRD;
        else if (bus.op == OP_SW) state_nxt = S_MEMWR;
        else                      state_nxt = S_FETCH;
      end
      S_MEMRD:   state_nxt = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_nxt = mem_done ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Moore decode; encodings 13-15 fall to the all-zero default.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = mem_done;
        ctrl.pcwrite = mem_done;
      end
      S_DECODE:  ctrl.alusrcb = 2'b11;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD:   ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsrc    = 2'b01;
        ctrl.branch   = (state == S_BEQEX);
        ctrl.branchne = (state == S_BNEEX);
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_ADDIWB:  ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default:   ctrl = '0;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  // Write enables are masked during reset so an abandoned instruction cannot commit.
  assign bus.iord      = ctrl.iord;
  assign bus.memwrite  = ctrl.memwrite & ~reset;
  assign bus.irwrite   = ctrl.irwrite & ~reset;
  assign bus.regdst    = ctrl.regdst;
  assign bus.memtoreg  = ctrl.memtoreg;
  assign bus.regwrite  = ctrl.regwrite & ~reset;
  assign bus.alusrca   = ctrl.alusrca;
  assign bus.alusrcb   = ctrl.alusrcb;
  assign bus.pcsrc     = ctrl.pcsrc;
  assign bus.pcen      = ~reset & (ctrl.pcwrite | (ctrl.branch & bus.zero) |
                                   (ctrl.branchne & ~bus.zero));
  assign bus.dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instruction sequences with
// hand-listed state traces; a monitor compares every queued expectation.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ILL  = 6'b111111;
  localparam logic [5:0] SLT  = 6'b101010;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  event sample_ev;

  mips_multicycle_ctrl_if #(.STATE_W(4)) bus ();

  mips_multicycle_ctrl #(.USE_MEMREADY(1'b1), .STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference control word {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  // alusrcb,pcsrc,alucontrol,pcen} for a given state and inputs.
  function automatic logic [14:0] model(input logic [3:0] st, input logic rst,
                                        input logic mr, input logic z,
                                        input logic [5:0] fn);
    logic iord, mw, irw, rd, mtr, rw, asa, pw, br, bn, pcen;
    logic [1:0] asb, ps, aop;
    logic [2:0] ac;
    {iord, mw, irw, rd, mtr, rw, asa, pw, br, bn} = '0;
    asb = 2'b00; ps = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin mtr = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pw = 1'b1; end
      4'd12: begin asa = 1'b1; aop = 2'b01; ps = 2'b01; bn = 1'b1; end
      default: ;
    endcase
    if (aop == 2'b01) ac = 3'b110;
    else if (aop == 2'b10) begin
      if (fn == 6'h20)      ac = 3'b010;
      else if (fn == 6'h22) ac = 3'b110;
      else if (fn == 6'h24) ac = 3'b000;
      else if (fn == 6'h25) ac = 3'b001;
      else if (fn == 6'h2a) ac = 3'b111;
      else                  ac = 3'b010;
    end else ac = 3'b010;
    pcen = pw | (br & z) | (bn & ~z);
    if (rst) begin mw = 1'b0; irw = 1'b0; rw = 1'b0; pcen = 1'b0; end
    return {iord, mw, irw, rd, mtr, rw, asa, asb, ps, ac, pcen};
  endfunction

  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m);
    reset = r; bus.op = o; bus.funct = f; bus.zero = z; bus.memready = m;
  endtask

  // One clock cycle: drive inputs, queue the expected state/controls, advance.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic m, input logic [3:0] st);
    drive(r, o, f, z, m);
    #1;
    exp_q.push_back('{st: st, ctl: model(st, r, m, z, f)});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every falling edge, or immediately for asynchronous checks.
  initial begin
    exp_t        e;
    logic [14:0] act;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
               bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.pcen};
        checks++;
        if (bus.dbg_state !== e.st) begin
          errors++;
          $display("FAIL state t=%0t got %0d want %0d", $time, bus.dbg_state, e.st);
        end
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctrl st=%0d t=%0t got %h want %h", e.st, $time, act, e.ctl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, LW, 6'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    // reset held two cycles, then lw: 0,1,2,3,4
    cyc(1, LW, 0, 0, 1, 4'd0);
    cyc(1, LW, 0, 0, 1, 4'd0);
    cyc(0, LW, 0, 0, 1, 4'd0);
    cyc(0, LW, 0, 0, 1, 4'd1);
    cyc(0, LW, 0, 0, 1, 4'd2);
    cyc(0, LW, 0, 0, 1, 4'd3);
    cyc(0, LW, 0, 0, 1, 4'd4);
    // sw with three wait cycles in MEMWR
    cyc(0, SW, 0, 0, 1, 4'd0);
    cyc(0, SW, 0, 0, 1, 4'd1);
    cyc(0, SW, 0, 0, 1, 4'd2);
    cyc(0, SW, 0, 0, 0, 4'd5);
    cyc(0, SW, 0, 0, 0, 4'd5);
    cyc(0, SW, 0, 0, 0, 4'd5);
    cyc(0, SW, 0, 0, 1, 4'd5);
    // fetch stalled two cycles, then j
    cyc(0, JMP, 0, 0, 0, 4'd0);
    cyc(0, JMP, 0, 0, 0, 4'd0);
    cyc(0, JMP, 0, 0, 1, 4'd0);
    cyc(0, JMP, 0, 0, 1, 4'd1);
    cyc(0, JMP, 0, 0, 1, 4'd11);
    // beq taken, bne not taken, bne taken
    cyc(0, BEQ, 0, 1, 1, 4'd0);
    cyc(0, BEQ, 0, 1, 1, 4'd1);
    cyc(0, BEQ, 0, 1, 1, 4'd8);
    cyc(0, BNE, 0, 1, 1, 4'd0);
    cyc(0, BNE, 0, 1, 1, 4'd1);
    cyc(0, BNE, 0, 1, 1, 4'd12);
    cyc(0, BNE, 0, 0, 1, 4'd0);
    cyc(0, BNE, 0, 0, 1, 4'd1);
    cyc(0, BNE, 0, 0, 1, 4'd12);
    // R-type slt, addi, illegal opcode
    cyc(0, RT, SLT, 0, 1, 4'd0);
    cyc(0, RT, SLT, 0, 1, 4'd1);
    cyc(0, RT, SLT, 0, 1, 4'd6);
    cyc(0, RT, SLT, 0, 1, 4'd7);
    cyc(0, ADDI, 0, 0, 1, 4'd0);
    cyc(0, ADDI, 0, 0, 1, 4'd1);
    cyc(0, ADDI, 0, 0, 1, 4'd9);
    cyc(0, ADDI, 0, 0, 1, 4'd10);
    cyc(0, ILL, 0, 0, 1, 4'd0);
    cyc(0, ILL, 0, 0, 1, 4'd1);
    // sw interrupted by reset while the write strobe is high
    cyc(0, SW, 0, 0, 1, 4'd0);
    cyc(0, SW, 0, 0, 1, 4'd1);
    cyc(0, SW, 0, 0, 1, 4'd2);
    drive(0, SW, 0, 0, 0);
    #1;
    exp_q.push_back('{st: 4'd5, ctl: model(4'd5, 1'b0, 1'b0, 1'b0, 6'd0)});
    #5;
    drive(1, SW, 0, 0, 1);
    #1;
    exp_q.push_back('{st: 4'd0, ctl: model(4'd0, 1'b1, 1'b1, 1'b0, 6'd0)});
    ->sample_ev;
    @(posedge clk);
    #1;
    cyc(1, LW, 0, 0, 1, 4'd0);
    cyc(0, LW, 0, 0, 1, 4'd0);
    cyc(0, LW, 0, 0, 1, 4'd1);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
